// File: rtl/descrambler_pkg.sv
// Shared types and symbol constants for the receive descrambler sequencer.
// Block-state encoding is visible on the blk_state debug port.
package descrambler_pkg;

  typedef enum logic [2:0] {
    BLK_IDLE  = 3'd0,
    BLK_DATA  = 3'd1,
    BLK_OS    = 3'd2,
    BLK_SKP   = 3'd3,
    BLK_EIEOS = 3'd4
  } blk_state_t;

  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam logic [7:0] SKP_K_SYM = 8'h1C;
  localparam logic [7:0] SKP_OS_ID = 8'hAA;
  localparam logic [7:0] EIEOS_ID  = 8'h00;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

endpackage

// File: rtl/descrambler_sequencer_sym_classifier.sv
// Per-byte symbol decode: 8b/10b COM / SKP K-codes and the ordered-set
// type a byte would select if it were symbol 0 of a 128b/130b block.
module sym_classifier
  import descrambler_pkg::*;
(
  input  logic [7:0]  sym,
  input  logic        k,
  output logic        is_com,
  output logic        is_skp_k,
  output blk_state_t  os_kind
);

  always_comb begin
    is_com   = k && (sym == COM_SYM);
    is_skp_k = k && (sym == SKP_K_SYM);
    if (sym == SKP_OS_ID)     os_kind = BLK_SKP;
    else if (sym == EIEOS_ID) os_kind = BLK_EIEOS;
    else                      os_kind = BLK_OS;
  end

endmodule

// File: rtl/descrambler_sequencer.sv
// Per-lane receive descrambler control: derives LFSR advance, descramble
// enable and LFSR reload from 8b/10b K context or 128b/130b block framing.
module descrambler_sequencer
  import descrambler_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             gen,
  input  logic [5:0]             pipe_width,
  input  logic                   data_valid,
  input  logic                   start_block,
  input  logic [1:0]             sync_header,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [MAX_BYTES-1:0]   datak,
  output logic [MAX_BYTES-1:0]   advance,
  output logic [MAX_BYTES-1:0]   desc_en,
  output logic                   lfsr_reset,
  output blk_state_t             blk_state,
  output logic [3:0]             sym_cnt,
  output logic                   frame_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  // Handshake: data_valid qualifies a beat; there is no backpressure, so
  // every valid beat is consumed in the cycle it is presented.

  blk_state_t           state_q, state_d, eff_state, hdr_kind;
  logic [3:0]           sym_q, sym_d, eff_sym, n_bytes;
  logic [2:0]           gen_q;
  logic [MAX_BYTES-1:0] lane_mask, is_com, is_skp_k;
  logic                 mode130, gen_change, fixed_blk, hdr_ok, err_det;
  blk_state_t           os_kind [MAX_BYTES];

  for (genvar i = 0; i < MAX_BYTES; i++) begin : g_lane
    sym_classifier u_cls (
      .sym      (data[8*i +: 8]),
      .k        (datak[i]),
      .is_com   (is_com[i]),
      .is_skp_k (is_skp_k[i]),
      .os_kind  (os_kind[i])
    );
  end

  always_comb begin
    case (pipe_width)
      6'd8:    n_bytes = 4'd1;
      6'd16:   n_bytes = 4'd2;
      default: n_bytes = 4'(MAX_BYTES);
    endcase
    for (int i = 0; i < MAX_BYTES; i++) lane_mask[i] = (4'(i) < n_bytes);
  end

  // Effective block context for the current beat: a start_block beat is
  // decoded as symbol 0 of the new block with zero latency; a finished
  // fixed-length block or a gen change falls back to IDLE.
  always_comb begin
    mode130    = (gen >= 3'd3);
    gen_change = (gen != gen_q);
    fixed_blk  = (state_q == BLK_DATA) || (state_q == BLK_OS) || (state_q == BLK_EIEOS);
    hdr_ok     = (sync_header == SYNC_DATA) || (sync_header == SYNC_OS);
    hdr_kind   = (sync_header == SYNC_DATA) ? BLK_DATA : os_kind[0];
    eff_state  = BLK_IDLE;
    eff_sym    = 4'd0;
    err_det    = 1'b0;
    if (data_valid && mode130) begin
      if (start_block) begin
        eff_state = hdr_ok ? hdr_kind : BLK_IDLE;
        err_det   = !hdr_ok || (fixed_blk && (sym_q != 4'd0) && !gen_change);
      end else if (!gen_change && !(fixed_blk && (sym_q == 4'd0))) begin
        eff_state = state_q;
        eff_sym   = sym_q;
      end
    end
    state_d = eff_state;
    sym_d   = (eff_state == BLK_IDLE) ? 4'd0 : eff_sym + n_bytes;
  end

  always_comb begin
    advance    = '0;
    desc_en    = '0;
    lfsr_reset = 1'b0;
    if (data_valid) begin
      if (!mode130) begin
        advance    = lane_mask & ~is_skp_k;
        desc_en    = lane_mask & ~datak;
        lfsr_reset = |(lane_mask & is_com);
      end else begin
        case (eff_state)
          BLK_DATA: begin
            advance = lane_mask;
            desc_en = lane_mask;
          end
          BLK_OS: begin
            advance = lane_mask;
            desc_en = lane_mask & ~{{(MAX_BYTES-1){1'b0}}, (eff_sym == 4'd0)};
          end
          BLK_EIEOS: lfsr_reset = ({1'b0, eff_sym} + {1'b0, n_bytes}) >= 5'd16;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= BLK_IDLE;
      sym_q     <= 4'd0;
      gen_q     <= 3'd0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_det;
      if (data_valid) begin
        state_q <= state_d;
        sym_q   <= sym_d;
        gen_q   <= gen;
        if (err_det && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign blk_state = state_q;
  assign sym_cnt   = sym_q;

endmodule

// File: tb/tb_descrambler_sequencer.sv
// Self-checking bench for descrambler_sequencer: directed scenarios plus
// randomized beats checked against a block-level reference model.
module tb_descrambler_sequencer;
  import descrambler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  gen = 3'd0;
  logic [5:0]  pipe_width = 6'd32;
  logic        data_valid = 1'b0;
  logic        start_block = 1'b0;
  logic [1:0]  sync_header = 2'b00;
  logic [31:0] data = '0;
  logic [3:0]  datak = '0;
  logic [3:0]  advance, desc_en;
  logic        lfsr_reset, frame_err;
  blk_state_t  blk_state;
  logic [3:0]  sym_cnt;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  blk_state_t m_kind = BLK_IDLE;
  int         m_pos = 0;
  logic [2:0] m_gen = 3'd0;
  int         m_errs = 0;
  logic       m_ferr = 1'b0;
  logic [3:0] exp_adv, exp_den;
  logic       exp_lrst;

  descrambler_sequencer #(.MAX_BYTES(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .gen(gen), .pipe_width(pipe_width),
    .data_valid(data_valid), .start_block(start_block), .sync_header(sync_header),
    .data(data), .datak(datak), .advance(advance), .desc_en(desc_en),
    .lfsr_reset(lfsr_reset), .blk_state(blk_state), .sym_cnt(sym_cnt),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic int exp_sym();
    return (m_kind == BLK_IDLE) ? 0 : (m_pos % 16);
  endfunction

  // Block-level model: tracks symbols consumed in the current block.
  task automatic model_beat();
    int n;
    int s;
    logic fixed_b, err;
    logic [7:0] b;
    n = (pipe_width == 6'd8) ? 1 : (pipe_width == 6'd16) ? 2 : 4;
    exp_adv = '0; exp_den = '0; exp_lrst = 1'b0; m_ferr = 1'b0;
    if (!data_valid) return;
    if (gen < 3'd3) begin
      for (int i = 0; i < n; i++) begin
        b = data[8*i +: 8];
        exp_adv[i] = !(datak[i] && b == 8'h1C);
        exp_den[i] = !datak[i];
        if (datak[i] && b == 8'hBC) exp_lrst = 1'b1;
      end
      m_kind = BLK_IDLE;
      m_pos = 0;
    end else begin
      fixed_b = (m_kind == BLK_DATA) || (m_kind == BLK_OS) || (m_kind == BLK_EIEOS);
      err = 1'b0;
      if (start_block) begin
        if (fixed_b && m_pos < 16 && gen == m_gen) err = 1'b1;
        m_pos = 0;
        if (sync_header == 2'b01) m_kind = BLK_DATA;
        else if (sync_header == 2'b10)
          m_kind = (data[7:0] == 8'hAA) ? BLK_SKP : (data[7:0] == 8'h00) ? BLK_EIEOS : BLK_OS;
        else begin
          m_kind = BLK_IDLE;
          err = 1'b1;
        end
      end else if (gen != m_gen || (fixed_b && m_pos >= 16)) begin
        m_kind = BLK_IDLE;
      end
      for (int i = 0; i < n; i++) begin
        s = m_pos + i;
        if (m_kind == BLK_DATA) begin exp_adv[i] = 1'b1; exp_den[i] = 1'b1; end
        if (m_kind == BLK_OS) begin exp_adv[i] = 1'b1; exp_den[i] = (s != 0); end
        if (m_kind == BLK_EIEOS && s == 15) exp_lrst = 1'b1;
      end
      if (m_kind == BLK_IDLE) m_pos = 0;
      else m_pos = m_pos + n;
      m_ferr = err;
      if (err && m_errs < 255) m_errs++;
    end
    m_gen = gen;
  endtask

  task automatic drive(input logic v, input logic [2:0] g, input logic [5:0] pw, input logic sb,
                       input logic [1:0] sh, input logic [31:0] d, input logic [3:0] k);
    @(negedge clk);
    data_valid = v; gen = g; pipe_width = pw; start_block = sb;
    sync_header = sh; data = d; datak = k;
    #1;
    model_beat();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    data_valid = 1'b0; start_block = 1'b0; gen = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_kind = BLK_IDLE; m_pos = 0; m_gen = 3'd0; m_errs = 0; m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks += 4;
    if (blk_state !== BLK_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", blk_state, BLK_IDLE); end
    if (sym_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sym: got %0d expected 0", sym_cnt); end
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_8b10b();
    drive(1, 3'd1, 6'd32, 0, 2'b00, 32'h1CBC4512, 4'b1100);
    n_checks += 3;
    if (advance !== 4'b0111) begin n_fail++; $display("FAIL k_advance: got %b expected 0111", advance); end
    if (desc_en !== 4'b0011) begin n_fail++; $display("FAIL k_desc_en: got %b expected 0011", desc_en); end
    if (lfsr_reset !== 1'b1) begin n_fail++; $display("FAIL k_lfsr_reset: got %b expected 1", lfsr_reset); end
    tick();
    // COM sits in a lane beyond the 8-bit width: must be ignored
    drive(1, 3'd2, 6'd8, 0, 2'b00, 32'h00BC0011, 4'b0100);
    n_checks += 3;
    if (advance !== exp_adv) begin n_fail++; $display("FAIL k_w8_advance: got %b expected %b", advance, exp_adv); end
    if (desc_en !== exp_den) begin n_fail++; $display("FAIL k_w8_desc_en: got %b expected %b", desc_en, exp_den); end
    if (lfsr_reset !== 1'b0) begin n_fail++; $display("FAIL k_w8_lfsr_reset: got %b expected 0", lfsr_reset); end
    tick();
  endtask

  task automatic test_data_block();
    for (int k = 0; k < 16; k++) begin
      drive(1, 3'd3, 6'd8, k == 0, 2'b01, $urandom, 4'($urandom));
      n_checks += 3;
      if (advance !== 4'b0001) begin n_fail++; $display("FAIL data_advance beat %0d: got %b expected 0001", k, advance); end
      if (desc_en !== 4'b0001) begin n_fail++; $display("FAIL data_desc_en beat %0d: got %b expected 0001", k, desc_en); end
      if (sym_cnt !== 4'(k)) begin n_fail++; $display("FAIL data_sym_cnt beat %0d: got %0d expected %0d", k, sym_cnt, k); end
      tick();
    end
    drive(1, 3'd3, 6'd8, 0, 2'b01, $urandom, 4'd0);
    n_checks += 1;
    if (advance !== 4'b0000) begin n_fail++; $display("FAIL data_after_advance: got %b expected 0000", advance); end
    tick();
    n_checks += 1;
    if (blk_state !== BLK_IDLE) begin n_fail++; $display("FAIL data_end_state: got %0d expected %0d", blk_state, BLK_IDLE); end
  endtask

  task automatic test_os_block();
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'd3, 6'd32, k == 0, 2'b10, {$urandom_range(0, 32'hFFFFFF), 8'h1E}, 4'd0);
      n_checks += 2;
      if (advance !== 4'b1111) begin n_fail++; $display("FAIL os_advance beat %0d: got %b expected 1111", k, advance); end
      if (desc_en !== ((k == 0) ? 4'b1110 : 4'b1111)) begin
        n_fail++; $display("FAIL os_desc_en beat %0d: got %b expected %b", k, desc_en, (k == 0) ? 4'b1110 : 4'b1111);
      end
      tick();
    end
  endtask

  task automatic test_eieos();
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'd3, 6'd16, k == 0, 2'b10, {$urandom_range(0, 32'hFFFFFF), 8'h00}, 4'd0);
      n_checks += 2;
      if (advance !== 4'b0000) begin n_fail++; $display("FAIL eieos_advance beat %0d: got %b expected 0000", k, advance); end
      if (lfsr_reset !== (k == 7)) begin n_fail++; $display("FAIL eieos_lfsr_reset beat %0d: got %b expected %b", k, lfsr_reset, k == 7); end
      tick();
    end
  endtask

  task automatic test_skp();
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd3, 6'd32, k == 0, 2'b10, (k == 0) ? 32'h123456AA : $urandom, 4'd0);
      n_checks += 2;
      if (advance !== 4'b0000) begin n_fail++; $display("FAIL skp_advance beat %0d: got %b expected 0000", k, advance); end
      if (desc_en !== 4'b0000) begin n_fail++; $display("FAIL skp_desc_en beat %0d: got %b expected 0000", k, desc_en); end
      tick();
    end
    drive(1, 3'd3, 6'd32, 1, 2'b01, $urandom, 4'd0);
    n_checks += 1;
    if (advance !== 4'b1111) begin n_fail++; $display("FAIL skp_to_data_advance: got %b expected 1111", advance); end
    tick();
    n_checks += 2;
    if (blk_state !== BLK_DATA) begin n_fail++; $display("FAIL skp_to_data_state: got %0d expected %0d", blk_state, BLK_DATA); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL skp_to_data_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_errors();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'd3, 6'd8, k == 0, 2'b01, $urandom, 4'd0);
      tick();
    end
    n_checks += 1;
    if (sym_cnt !== 4'd8) begin n_fail++; $display("FAIL err_sym_before: got %0d expected 8", sym_cnt); end
    drive(1, 3'd3, 6'd8, 1, 2'b01, $urandom, 4'd0);
    tick();
    n_checks += 3;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL err_resync_pulse: got %b expected 1", frame_err); end
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_resync_cnt: got %0d expected 1", err_cnt); end
    if (blk_state !== BLK_DATA) begin n_fail++; $display("FAIL err_resync_state: got %0d expected %0d", blk_state, BLK_DATA); end
    drive(1, 3'd3, 6'd8, 1, 2'b11, $urandom, 4'd0);
    n_checks += 1;
    if (advance !== 4'b0000) begin n_fail++; $display("FAIL err_hdr_advance: got %b expected 0000", advance); end
    tick();
    n_checks += 3;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL err_hdr_pulse: got %b expected 1", frame_err); end
    if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL err_hdr_cnt: got %0d expected 2", err_cnt); end
    if (blk_state !== BLK_IDLE) begin n_fail++; $display("FAIL err_hdr_state: got %0d expected %0d", blk_state, BLK_IDLE); end
    drive(0, 3'd3, 6'd8, 0, 2'b01, 32'd0, 4'd0);
    tick();
    n_checks += 1;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b expected 0", frame_err); end
  endtask

  task automatic test_reset_mid();
    drive(1, 3'd3, 6'd32, 1, 2'b01, $urandom, 4'd0);
    tick();
    drive(1, 3'd3, 6'd32, 0, 2'b01, $urandom, 4'd0);
    #1 reset = 1'b0;
    #1;
    n_checks += 5;
    if (blk_state !== BLK_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", blk_state, BLK_IDLE); end
    if (sym_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_sym: got %0d expected 0", sym_cnt); end
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_errcnt: got %0d expected 0", err_cnt); end
    if (advance !== 4'b0000 || desc_en !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_byte_ctl: got %b/%b expected 0000/0000", advance, desc_en);
    end
    if (lfsr_reset !== 1'b0) begin n_fail++; $display("FAIL rstmid_lfsr_reset: got %b expected 0", lfsr_reset); end
    do_reset();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 260; k++) begin
      drive(1, 3'd4, 6'd32, 1, 2'b00, $urandom, 4'd0);
      tick();
    end
    n_checks += 1;
    if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL err_saturate: got %0d expected 255", err_cnt); end
  endtask

  task automatic test_random();
    logic [2:0]  g;
    logic [5:0]  pw;
    logic [1:0]  sh;
    logic [31:0] d;
    int r;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      case ($urandom_range(0, 3))
        0: pw = 6'd8;
        1: pw = 6'd16;
        2: pw = 6'd32;
        default: pw = 6'd24;
      endcase
      g = 3'd3;
      for (int bt = 0; bt < 300; bt++) begin
        r = $urandom_range(0, 99);
        if (r < 3) g = 3'($urandom_range(1, 2));
        else if (r < 8) g = 3'($urandom_range(3, 4));
        d = $urandom;
        for (int i = 0; i < 4; i++) begin
          r = $urandom_range(0, 7);
          if (r == 0) d[8*i +: 8] = 8'hBC;
          else if (r == 1) d[8*i +: 8] = 8'h1C;
        end
        case ($urandom_range(0, 4))
          0: d[7:0] = 8'hAA;
          1: d[7:0] = 8'h00;
          2: d[7:0] = 8'h1E;
          default: ;
        endcase
        r = $urandom_range(0, 19);
        sh = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 10) ? 2'b01 : 2'b10;
        drive($urandom_range(0, 9) < 8, g, pw, $urandom_range(0, 99) < 15, sh, d, 4'($urandom));
        n_checks += 3;
        if (advance !== exp_adv) begin n_fail++; $display("FAIL rnd_advance seg %0d beat %0d: got %b expected %b", seg, bt, advance, exp_adv); end
        if (desc_en !== exp_den) begin n_fail++; $display("FAIL rnd_desc_en seg %0d beat %0d: got %b expected %b", seg, bt, desc_en, exp_den); end
        if (lfsr_reset !== exp_lrst) begin n_fail++; $display("FAIL rnd_lfsr_reset seg %0d beat %0d: got %b expected %b", seg, bt, lfsr_reset, exp_lrst); end
        tick();
        n_checks += 4;
        if (blk_state !== m_kind) begin n_fail++; $display("FAIL rnd_state seg %0d beat %0d: got %0d expected %0d", seg, bt, blk_state, m_kind); end
        if (sym_cnt !== 4'(exp_sym())) begin n_fail++; $display("FAIL rnd_sym seg %0d beat %0d: got %0d expected %0d", seg, bt, sym_cnt, exp_sym()); end
        if (frame_err !== m_ferr) begin n_fail++; $display("FAIL rnd_frame_err seg %0d beat %0d: got %b expected %b", seg, bt, frame_err, m_ferr); end
        if (err_cnt !== 8'(m_errs)) begin n_fail++; $display("FAIL rnd_err_cnt seg %0d beat %0d: got %0d expected %0d", seg, bt, err_cnt, m_errs); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_8b10b();
    test_data_block();
    test_os_block();
    test_eieos();
    test_skp();
    test_errors();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
